// File: rtl/ycbcr2rgb.sv
// ycbcr2rgb: full-range YCbCr 4:4:4 to RGB565 with a fixed 4-cycle pipeline and matched syncs.
// Optional 2x2 ordered dither before the 888->565 truncation: define YCBCR2RGB_DITHER_EN.
module ycbcr2rgb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pre_frame_vsync,
    input  logic       pre_frame_hsync,
    input  logic       pre_frame_de,
    input  logic [7:0] img_y,
    input  logic [7:0] img_cb,
    input  logic [7:0] img_cr,
    output logic       post_frame_vsync,
    output logic       post_frame_hsync,
    output logic       post_frame_de,
    output logic [4:0] img_red,
    output logic [5:0] img_green,
    output logic [4:0] img_blue
);

    logic signed [8:0]  cb_c_s, cr_c_s;
    logic signed [18:0] cb_w_s, cr_w_s;
    logic signed [18:0] y_d, r_cr_d, g_cb_d, g_cr_d, b_cb_d;
    logic signed [18:0] y_q, r_cr_q, g_cb_q, g_cr_q, b_cb_q;
    logic signed [19:0] r_sum_d, g_sum_d, b_sum_d;
    logic signed [19:0] r_sum_q, g_sum_q, b_sum_q;
    logic [7:0]         r8_d, g8_d, b8_d;
    logic [7:0]         r8_q, g8_q, b8_q;
    logic [7:0]         r_dith_s, g_dith_s, b_dith_s;
    logic [4:0]         red_d, red_q, blue_d, blue_q;
    logic [5:0]         green_d, green_q;
    logic [3:0]         vs_q, hs_q, de_q;

    function automatic logic signed [19:0] sx20(input logic signed [18:0] v);
        return {v[18], v};
    endfunction

    function automatic logic [7:0] sat8(input logic signed [19:0] s);
        logic signed [19:0] sh;
        sh = s >>> 8;
        if (sh < 20'sd0) begin
            return 8'd0;
        end else if (sh > 20'sd255) begin
            return 8'd255;
        end else begin
            return sh[7:0];
        end
    endfunction

    // S1: centred chroma, per-channel products and scaled luma
    always_comb begin
        cb_c_s = $signed({1'b0, img_cb}) - 9'sd128;
        cr_c_s = $signed({1'b0, img_cr}) - 9'sd128;
        cb_w_s = $signed({{10{cb_c_s[8]}}, cb_c_s});
        cr_w_s = $signed({{10{cr_c_s[8]}}, cr_c_s});
        y_d    = $signed({3'b000, img_y, 8'h00});
        r_cr_d = cr_w_s * 19'sd359;
        g_cb_d = cb_w_s * 19'sd88;
        g_cr_d = cr_w_s * 19'sd183;
        b_cb_d = cb_w_s * 19'sd454;
    end

    // S2/S3: rounded sums, then shift and clamp to 8 bits
    always_comb begin
        r_sum_d = sx20(y_q) + sx20(r_cr_q) + 20'sd128;
        g_sum_d = sx20(y_q) - sx20(g_cb_q) - sx20(g_cr_q) + 20'sd128;
        b_sum_d = sx20(y_q) + sx20(b_cb_q) + 20'sd128;
        r8_d    = sat8(r_sum_q);
        g8_d    = sat8(g_sum_q);
        b8_d    = sat8(b_sum_q);
    end

`ifdef YCBCR2RGB_DITHER_EN
    logic col_q, row_q, col_d, row_d;

    function automatic logic [2:0] off3(input logic row, input logic col);
        case ({row, col})
            2'b00:   return 3'd0;
            2'b01:   return 3'd4;
            2'b10:   return 3'd6;
            2'b11:   return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] off2(input logic row, input logic col);
        case ({row, col})
            2'b00:   return 3'd0;
            2'b01:   return 3'd2;
            2'b10:   return 3'd3;
            2'b11:   return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] dith(input logic [7:0] v, input logic [2:0] off);
        logic [8:0] s;
        s = {1'b0, v} + {6'd0, off};
        if (s[8]) begin
            return 8'hFF;
        end else begin
            return s[7:0];
        end
    endfunction

    // Bayer position tracks the S3-aligned de/vsync so offsets follow the pixel being reduced
    always_comb begin
        if (de_q[2]) begin
            col_d = ~col_q;
        end else if (de_q[3]) begin
            col_d = 1'b0;
        end else begin
            col_d = col_q;
        end
        if (vs_q[2] && !vs_q[3]) begin
            row_d = 1'b0;
        end else if (de_q[3] && !de_q[2]) begin
            row_d = ~row_q;
        end else begin
            row_d = row_q;
        end
        r_dith_s = dith(r8_q, off3(row_q, col_q));
        g_dith_s = dith(g8_q, off2(row_q, col_q));
        b_dith_s = dith(b8_q, off3(row_q, col_q));
    end

    // Dither position registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= 1'b0;
            row_q <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
`else
    // Plain truncation path
    always_comb begin
        r_dith_s = r8_q;
        g_dith_s = g8_q;
        b_dith_s = b8_q;
    end
`endif

    // S4: reduce to 565, blanked outside active video
    always_comb begin
        if (de_q[2]) begin
            red_d   = 5'(r_dith_s >> 3'd3);
            green_d = 6'(g_dith_s >> 3'd2);
            blue_d  = 5'(b_dith_s >> 3'd3);
        end else begin
            red_d   = 5'd0;
            green_d = 6'd0;
            blue_d  = 5'd0;
        end
    end

    // Pipeline data registers and sync delay lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= 19'sd0;
            r_cr_q  <= 19'sd0;
            g_cb_q  <= 19'sd0;
            g_cr_q  <= 19'sd0;
            b_cb_q  <= 19'sd0;
            r_sum_q <= 20'sd0;
            g_sum_q <= 20'sd0;
            b_sum_q <= 20'sd0;
            r8_q    <= 8'd0;
            g8_q    <= 8'd0;
            b8_q    <= 8'd0;
            red_q   <= 5'd0;
            green_q <= 6'd0;
            blue_q  <= 5'd0;
            vs_q    <= 4'd0;
            hs_q    <= 4'd0;
            de_q    <= 4'd0;
        end else begin
            y_q     <= y_d;
            r_cr_q  <= r_cr_d;
            g_cb_q  <= g_cb_d;
            g_cr_q  <= g_cr_d;
            b_cb_q  <= b_cb_d;
            r_sum_q <= r_sum_d;
            g_sum_q <= g_sum_d;
            b_sum_q <= b_sum_d;
            r8_q    <= r8_d;
            g8_q    <= g8_d;
            b8_q    <= b8_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            vs_q    <= {vs_q[2:0], pre_frame_vsync};
            hs_q    <= {hs_q[2:0], pre_frame_hsync};
            de_q    <= {de_q[2:0], pre_frame_de};
        end
    end

    assign post_frame_vsync = vs_q[3];
    assign post_frame_hsync = hs_q[3];
    assign post_frame_de    = de_q[3];
    assign img_red          = red_q;
    assign img_green        = green_q;
    assign img_blue         = blue_q;

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Self-checking bench for ycbcr2rgb: table vectors, hand-written sync/reset/dither sequences,
// and random pixels, all compared through a latency-matched scoreboard queue.
module tb_ycbcr2rgb;

    logic       clk;
    logic       rst_n;
    logic       pre_frame_vsync, pre_frame_hsync, pre_frame_de;
    logic [7:0] img_y, img_cb, img_cr;
    logic       post_frame_vsync, post_frame_hsync, post_frame_de;
    logic [4:0] img_red;
    logic [5:0] img_green;
    logic [4:0] img_blue;

    ycbcr2rgb dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pre_frame_vsync  (pre_frame_vsync),
        .pre_frame_hsync  (pre_frame_hsync),
        .pre_frame_de     (pre_frame_de),
        .img_y            (img_y),
        .img_cb           (img_cb),
        .img_cr           (img_cr),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_hsync (post_frame_hsync),
        .post_frame_de    (post_frame_de),
        .img_red          (img_red),
        .img_green        (img_green),
        .img_blue         (img_blue)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       vs;
        logic       hs;
        logic       de;
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } exp_t;

    typedef struct {
        logic [7:0] y;
        logic [7:0] cb;
        logic [7:0] cr;
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } vec_t;

    exp_t sb_q[$];
    int   n_err;
    int   n_chk;
    bit   m_row, m_col, m_de_prev, m_vs_prev;

    function automatic int clamp8(input int v);
        if (v < 0) return 0;
        else if (v > 255) return 255;
        else return v;
    endfunction

    function automatic int sat_add(input int v, input int off);
        if (v + off > 255) return 255;
        else return v + off;
    endfunction

    task automatic chk(input string nm, input exp_t got, input exp_t want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got vs=%0b hs=%0b de=%0b rgb=%0d/%0d/%0d, want vs=%0b hs=%0b de=%0b rgb=%0d/%0d/%0d",
                     nm, got.vs, got.hs, got.de, got.r, got.g, got.b,
                     want.vs, want.hs, want.de, want.r, want.g, want.b);
        end
    endtask

    function automatic exp_t outs();
        exp_t o;
        o = {post_frame_vsync, post_frame_hsync, post_frame_de, img_red, img_green, img_blue};
        return o;
    endfunction

    task automatic sb_restart();
        exp_t z;
        z = '0;
        sb_q.delete();
        for (int i = 0; i < 3; i++) sb_q.push_back(z);
        m_row = 1'b0; m_col = 1'b0; m_de_prev = 1'b0; m_vs_prev = 1'b0;
    endtask

    // Drive one pixel, queue its expected output, clock once and compare the oldest entry.
    task automatic step(input string nm, input logic vs, input logic hs, input logic de,
                        input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                        input bit use_tbl, input logic [4:0] tr, input logic [5:0] tg,
                        input logic [4:0] tb);
        int yi, cbi, cri, r8, g8, b8, o3, o2;
        exp_t e, want;
        yi = int'(y); cbi = int'(cb); cri = int'(cr);
        r8 = clamp8((256 * yi + 359 * (cri - 128) + 128) >>> 8);
        g8 = clamp8((256 * yi - 88 * (cbi - 128) - 183 * (cri - 128) + 128) >>> 8);
        b8 = clamp8((256 * yi + 454 * (cbi - 128) + 128) >>> 8);
`ifdef YCBCR2RGB_DITHER_EN
        o3 = m_row ? (m_col ? 2 : 6) : (m_col ? 4 : 0);
        o2 = m_row ? (m_col ? 1 : 3) : (m_col ? 2 : 0);
`else
        o3 = 0;
        o2 = 0;
`endif
        e.vs = vs; e.hs = hs; e.de = de;
        e.r = 5'(sat_add(r8, o3) >> 3);
        e.g = 6'(sat_add(g8, o2) >> 2);
        e.b = 5'(sat_add(b8, o3) >> 3);
        if (use_tbl) begin
            e.r = tr; e.g = tg; e.b = tb;
        end
        if (!de) begin
            e.r = 5'd0; e.g = 6'd0; e.b = 5'd0;
        end
        sb_q.push_back(e);
        if (vs && !m_vs_prev) m_row = 1'b0;
        else if (m_de_prev && !de) m_row = ~m_row;
        if (de) m_col = ~m_col;
        else m_col = 1'b0;
        m_de_prev = de; m_vs_prev = vs;

        pre_frame_vsync = vs; pre_frame_hsync = hs; pre_frame_de = de;
        img_y = y; img_cb = cb; img_cr = cr;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            want = sb_q.pop_front();
            chk(nm, outs(), want);
        end
    endtask

    task automatic px(input string nm, input logic vs, input logic hs, input logic de,
                      input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr);
        step(nm, vs, hs, de, y, cb, cr, 1'b0, 5'd0, 6'd0, 5'd0);
    endtask

    task automatic idle(input string nm, input int n);
        for (int i = 0; i < n; i++) px(nm, 1'b0, 1'b0, 1'b0, 8'd0, 8'd128, 8'd128);
    endtask

    vec_t tbl[6];
    logic [4:0] d_rb[4];

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t zero;
        zero = '0;
        n_err = 0;
        n_chk = 0;

        tbl[0] = '{8'd128, 8'd128, 8'd128, 5'd16, 6'd32, 5'd16};
        tbl[1] = '{8'd255, 8'd128, 8'd255, 5'd31, 6'd41, 5'd31};
        tbl[2] = '{8'd0,   8'd0,   8'd0,   5'd0,  6'd34, 5'd0};
        tbl[3] = '{8'd255, 8'd128, 8'd128, 5'd31, 6'd63, 5'd31};
        tbl[4] = '{8'd0,   8'd128, 8'd128, 5'd0,  6'd0,  5'd0};
        tbl[5] = '{8'd128, 8'd255, 8'd128, 5'd16, 6'd21, 5'd31};

        rst_n = 1'b1;
        pre_frame_vsync = 1'b0; pre_frame_hsync = 1'b0; pre_frame_de = 1'b0;
        img_y = 8'd0; img_cb = 8'd128; img_cr = 8'd128;
        #1 rst_n = 1'b0;
        #2 chk("reset_state", outs(), zero);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb_restart();
        idle("post_reset_idle", 4);

        for (int i = 0; i < 6; i++)
            step($sformatf("tbl%0d", i), 1'b0, 1'b1, 1'b1, tbl[i].y, tbl[i].cb, tbl[i].cr,
                 1'b1, tbl[i].r, tbl[i].g, tbl[i].b);
        idle("tbl_flush", 4);

        // 3-pixel line, then blanking with nonzero luma that must stay masked
        px("sync_vs", 1'b1, 1'b0, 1'b0, 8'd50, 8'd128, 8'd128);
        px("sync_p0", 1'b0, 1'b1, 1'b1, 8'd40, 8'd90, 8'd200);
        px("sync_p1", 1'b0, 1'b1, 1'b1, 8'd180, 8'd220, 8'd60);
        px("sync_p2", 1'b0, 1'b1, 1'b1, 8'd90, 8'd128, 8'd140);
        px("blank0", 1'b0, 1'b0, 1'b0, 8'd200, 8'd10, 8'd240);
        px("blank1", 1'b0, 1'b0, 1'b0, 8'd201, 8'd30, 8'd20);
        idle("sync_flush", 4);

        // Dither pattern: flat Y=100 over two 2-pixel lines after a vsync rising edge
`ifdef YCBCR2RGB_DITHER_EN
        d_rb[0] = 5'd12; d_rb[1] = 5'd13; d_rb[2] = 5'd13; d_rb[3] = 5'd12;
`else
        d_rb[0] = 5'd12; d_rb[1] = 5'd12; d_rb[2] = 5'd12; d_rb[3] = 5'd12;
`endif
        px("dith_vs", 1'b1, 1'b0, 1'b0, 8'd0, 8'd128, 8'd128);
        for (int ln = 0; ln < 2; ln++) begin
            for (int c = 0; c < 2; c++)
                step($sformatf("dith_l%0d_c%0d", ln, c), 1'b0, 1'b1, 1'b1, 8'd100, 8'd128, 8'd128,
                     1'b1, d_rb[ln * 2 + c], 6'd25, d_rb[ln * 2 + c]);
            idle("dith_gap", 2);
        end

        // Saturation at the largest dither offset (line1, col0)
        px("dsat_vs", 1'b1, 1'b0, 1'b0, 8'd0, 8'd128, 8'd128);
        for (int ln = 0; ln < 2; ln++) begin
            for (int c = 0; c < 2; c++)
                step($sformatf("dsat_l%0d_c%0d", ln, c), 1'b0, 1'b1, 1'b1, 8'd255, 8'd128, 8'd128,
                     1'b1, 5'd31, 6'd63, 5'd31);
            idle("dsat_gap", 2);
        end

        for (int i = 0; i < 40; i++)
            px($sformatf("rand%0d", i), 1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        idle("rand_flush", 4);

        // Asynchronous reset in the middle of an active line
        for (int i = 0; i < 6; i++)
            px($sformatf("pre_rst%0d", i), 1'b0, 1'b1, 1'b1, 8'(60 + 20 * i), 8'd150, 8'd170);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", outs(), zero);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb_restart();
        px("after_rst_vs", 1'b1, 1'b0, 1'b0, 8'd0, 8'd128, 8'd128);
        for (int i = 0; i < 4; i++)
            px($sformatf("after_rst%0d", i), 1'b0, 1'b1, 1'b1, 8'(30 + 50 * i), 8'd100, 8'd160);
        idle("final_flush", 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
